// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// mult/div FSM states and the hard-wired zero register.
package pipeline_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_t;

endpackage

// File: rtl/forward_select.sv
// Operand bypass select for one ID-stage source register; youngest producer wins.
module forward_select
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] SRC_REG,
    input  logic       SRC_USED,
    input  logic [4:0] EX_REGEX,
    input  logic       EX_RF_ENABLE,
    input  logic       EX_LOAD_INSTR,
    input  logic [4:0] MEM_REGEX,
    input  logic       MEM_RF_ENABLE,
    input  logic [4:0] WB_REGEX,
    input  logic       WB_RF_ENABLE,
    output logic [1:0] SEL
);

    always_comb begin
        SEL = FWD_RF;
        if (SRC_USED && SRC_REG != REG_ZERO) begin
            // A load in EX has no data yet; the hazard unit stalls instead.
            if (EX_RF_ENABLE && EX_REGEX == SRC_REG && !EX_LOAD_INSTR)
                SEL = FWD_EX;
            else if (MEM_RF_ENABLE && MEM_REGEX == SRC_REG)
                SEL = FWD_MEM;
            else if (WB_RF_ENABLE && WB_REGEX == SRC_REG)
                SEL = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing control for the 5-stage pipeline: forwarding selects,
// load-use and HI/LO stalls, mult/div busy tracking and a stall counter.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [4:0]             ID_RS,
    input  logic [4:0]             ID_RT,
    input  logic                   ID_USES_RS,
    input  logic                   ID_USES_RT,
    input  logic                   ID_IS_MULDIV,
    input  logic                   ID_READS_HILO,
    input  logic [4:0]             EX_REGEX,
    input  logic                   EX_RF_ENABLE,
    input  logic                   EX_LOAD_INSTR,
    input  logic [4:0]             MEM_REGEX,
    input  logic                   MEM_RF_ENABLE,
    input  logic [4:0]             WB_REGEX,
    input  logic                   WB_RF_ENABLE,
    output logic [1:0]             FWD_A_SEL,
    output logic [1:0]             FWD_B_SEL,
    output logic                   PC_LE,
    output logic                   IF_ID_LE,
    output logic                   ID_EX_BUBBLE,
    output logic                   MULDIV_BUSY,
    output logic                   MULDIV_DONE,
    output logic [STALL_CNT_W-1:0] STALL_COUNT
);

    localparam int CNT_W = 4;

    muldiv_state_t    state;
    logic [CNT_W-1:0] busy_cnt;
    logic [1:0]       fwd_a, fwd_b;
    logic             busy, done, load_use, hilo_haz, stall;

    forward_select u_fwd_a (
        .SRC_REG      (ID_RS),
        .SRC_USED     (ID_USES_RS),
        .EX_REGEX     (EX_REGEX),
        .EX_RF_ENABLE (EX_RF_ENABLE),
        .EX_LOAD_INSTR(EX_LOAD_INSTR),
        .MEM_REGEX    (MEM_REGEX),
        .MEM_RF_ENABLE(MEM_RF_ENABLE),
        .WB_REGEX     (WB_REGEX),
        .WB_RF_ENABLE (WB_RF_ENABLE),
        .SEL          (fwd_a)
    );

    forward_select u_fwd_b (
        .SRC_REG      (ID_RT),
        .SRC_USED     (ID_USES_RT),
        .EX_REGEX     (EX_REGEX),
        .EX_RF_ENABLE (EX_RF_ENABLE),
        .EX_LOAD_INSTR(EX_LOAD_INSTR),
        .MEM_REGEX    (MEM_REGEX),
        .MEM_RF_ENABLE(MEM_RF_ENABLE),
        .WB_REGEX     (WB_REGEX),
        .WB_RF_ENABLE (WB_RF_ENABLE),
        .SEL          (fwd_b)
    );

    assign busy     = (state == BUSY);
    assign done     = busy && (busy_cnt == '0);
    assign load_use = EX_LOAD_INSTR && EX_RF_ENABLE && (EX_REGEX != REG_ZERO) &&
                      ((ID_USES_RS && ID_RS == EX_REGEX) ||
                       (ID_USES_RT && ID_RT == EX_REGEX));
    // Includes the DONE cycle, so a following mult/div never overlaps.
    assign hilo_haz = busy && (ID_READS_HILO || ID_IS_MULDIV);
    assign stall    = load_use || hilo_haz;

    assign FWD_A_SEL    = Reset ? FWD_RF : fwd_a;
    assign FWD_B_SEL    = Reset ? FWD_RF : fwd_b;
    assign PC_LE        = Reset ? 1'b1   : !stall;
    assign IF_ID_LE     = Reset ? 1'b1   : !stall;
    assign ID_EX_BUBBLE = Reset ? 1'b0   : stall;
    assign MULDIV_BUSY  = Reset ? 1'b0   : busy;
    assign MULDIV_DONE  = Reset ? 1'b0   : done;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            busy_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (ID_IS_MULDIV && !stall) begin
                    state    <= BUSY;
                    busy_cnt <= CNT_W'(MULDIV_LAT - 1);
                end
                BUSY: if (busy_cnt == '0) state <= IDLE;
                      else                busy_cnt <= busy_cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            STALL_COUNT <= '0;
        else if (stall && STALL_COUNT != '1)
            STALL_COUNT <= STALL_COUNT + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; a second instance with a
// 4-bit stall counter exercises saturation.
module tb_pipeline_hazard_controller;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ID_RS, ID_RT, EX_REGEX, MEM_REGEX, WB_REGEX;
    logic        ID_USES_RS, ID_USES_RT, ID_IS_MULDIV, ID_READS_HILO;
    logic        EX_RF_ENABLE, EX_LOAD_INSTR, MEM_RF_ENABLE, WB_RF_ENABLE;
    logic [1:0]  FWD_A_SEL, FWD_B_SEL, fwd_a4, fwd_b4;
    logic        PC_LE, IF_ID_LE, ID_EX_BUBBLE, MULDIV_BUSY, MULDIV_DONE;
    logic        pc_le4, ifid_le4, bubble4, busy4, done4;
    logic [15:0] STALL_COUNT;
    logic [3:0]  stall_count4;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    pipeline_hazard_controller #(.MULDIV_LAT(4), .STALL_CNT_W(16)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_USES_RS(ID_USES_RS), .ID_USES_RT(ID_USES_RT),
        .ID_IS_MULDIV(ID_IS_MULDIV), .ID_READS_HILO(ID_READS_HILO),
        .EX_REGEX(EX_REGEX), .EX_RF_ENABLE(EX_RF_ENABLE), .EX_LOAD_INSTR(EX_LOAD_INSTR),
        .MEM_REGEX(MEM_REGEX), .MEM_RF_ENABLE(MEM_RF_ENABLE),
        .WB_REGEX(WB_REGEX), .WB_RF_ENABLE(WB_RF_ENABLE),
        .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL), .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE),
        .ID_EX_BUBBLE(ID_EX_BUBBLE), .MULDIV_BUSY(MULDIV_BUSY), .MULDIV_DONE(MULDIV_DONE),
        .STALL_COUNT(STALL_COUNT)
    );

    pipeline_hazard_controller #(.MULDIV_LAT(4), .STALL_CNT_W(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset),
        .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_USES_RS(ID_USES_RS), .ID_USES_RT(ID_USES_RT),
        .ID_IS_MULDIV(ID_IS_MULDIV), .ID_READS_HILO(ID_READS_HILO),
        .EX_REGEX(EX_REGEX), .EX_RF_ENABLE(EX_RF_ENABLE), .EX_LOAD_INSTR(EX_LOAD_INSTR),
        .MEM_REGEX(MEM_REGEX), .MEM_RF_ENABLE(MEM_RF_ENABLE),
        .WB_REGEX(WB_REGEX), .WB_RF_ENABLE(WB_RF_ENABLE),
        .FWD_A_SEL(fwd_a4), .FWD_B_SEL(fwd_b4), .PC_LE(pc_le4), .IF_ID_LE(ifid_le4),
        .ID_EX_BUBBLE(bubble4), .MULDIV_BUSY(busy4), .MULDIV_DONE(done4),
        .STALL_COUNT(stall_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        ID_RS = '0; ID_RT = '0; ID_USES_RS = 0; ID_USES_RT = 0;
        ID_IS_MULDIV = 0; ID_READS_HILO = 0;
        EX_REGEX = '0; EX_RF_ENABLE = 0; EX_LOAD_INSTR = 0;
        MEM_REGEX = '0; MEM_RF_ENABLE = 0; WB_REGEX = '0; WB_RF_ENABLE = 0;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        clr();
        Reset = 1'b1;
        // Inputs that would forward and stall; reset must mask them.
        ID_RS = 5'd5; ID_USES_RS = 1; EX_REGEX = 5'd5; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
        #3;
        chk("rst_fwd_a", FWD_A_SEL, 0);
        chk("rst_pc_le", PC_LE, 1);
        chk("rst_ifid_le", IF_ID_LE, 1);
        chk("rst_bubble", ID_EX_BUBBLE, 0);
        chk("rst_busy", MULDIV_BUSY, 0);
        chk("rst_done", MULDIV_DONE, 0);
        chk("rst_count", STALL_COUNT, 0);
        clr();
        step();
        Reset = 1'b0;
        step();

        // Forwarding priority EX > MEM > WB
        ID_RS = 5'd5; ID_USES_RS = 1;
        EX_REGEX = 5'd5; EX_RF_ENABLE = 1;
        MEM_REGEX = 5'd5; MEM_RF_ENABLE = 1;
        WB_REGEX = 5'd5; WB_RF_ENABLE = 1;
        #1 chk("fwd_ex", FWD_A_SEL, 1);
        EX_RF_ENABLE = 0;
        #1 chk("fwd_mem", FWD_A_SEL, 2);
        MEM_RF_ENABLE = 0;
        #1 chk("fwd_wb", FWD_A_SEL, 3);
        ID_USES_RS = 0;
        #1 chk("fwd_unused", FWD_A_SEL, 0);
        ID_RT = 5'd5; ID_USES_RT = 1; MEM_RF_ENABLE = 1;
        #1 chk("fwd_b_mem", FWD_B_SEL, 2);
        clr();

        // Register $0 never forwards
        ID_USES_RS = 1; ID_USES_RT = 1;
        EX_RF_ENABLE = 1; MEM_RF_ENABLE = 1; WB_RF_ENABLE = 1;
        #1 chk("zero_a", FWD_A_SEL, 0);
        chk("zero_b", FWD_B_SEL, 0);
        chk("zero_nostall", PC_LE, 1);
        EX_LOAD_INSTR = 1;
        #1 chk("zero_load_nostall", ID_EX_BUBBLE, 0);
        clr();

        // Load-use: one stall, then forward from MEM
        EX_REGEX = 5'd8; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
        ID_RT = 5'd8; ID_USES_RT = 1;
        #1 chk("lu_pc_le", PC_LE, 0);
        chk("lu_ifid_le", IF_ID_LE, 0);
        chk("lu_bubble", ID_EX_BUBBLE, 1);
        chk("lu_fwd_b_not_ex", FWD_B_SEL, 0);
        chk("lu_count0", STALL_COUNT, 0);
        step();
        chk("lu_count1", STALL_COUNT, 1);
        EX_REGEX = '0; EX_RF_ENABLE = 0; EX_LOAD_INSTR = 0;
        MEM_REGEX = 5'd8; MEM_RF_ENABLE = 1;
        #1 chk("lu_after_pc_le", PC_LE, 1);
        chk("lu_after_fwd_b", FWD_B_SEL, 2);
        step();
        chk("lu_after_count", STALL_COUNT, 1);
        clr();

        // MULT then MFHI: four stall cycles, DONE on the fourth
        ID_IS_MULDIV = 1;
        #1 chk("md_issue_pc_le", PC_LE, 1);
        step();
        ID_IS_MULDIV = 0; ID_READS_HILO = 1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            chk("md_busy", MULDIV_BUSY, 1);
            chk("md_stall", PC_LE, 0);
            chk("md_done", MULDIV_DONE, (i == 4) ? 1 : 0);
            step();
        end
        chk("md_idle", MULDIV_BUSY, 0);
        chk("md_done_clear", MULDIV_DONE, 0);
        chk("md_mfhi_go", PC_LE, 1);
        chk("md_count", STALL_COUNT, 5);
        step();
        clr();

        // Reset in the 2nd BUSY cycle aborts the operation
        ID_IS_MULDIV = 1;
        step();
        ID_IS_MULDIV = 0;
        step();
        chk("ab_busy2", MULDIV_BUSY, 1);
        #2 Reset = 1'b1;
        #1 chk("ab_busy", MULDIV_BUSY, 0);
        chk("ab_done", MULDIV_DONE, 0);
        chk("ab_count", STALL_COUNT, 0);
        #1 Reset = 1'b0;
        ID_IS_MULDIV = 1;
        #1 chk("ab_issue_nostall", PC_LE, 1);
        step();
        chk("ab_issued", MULDIV_BUSY, 1);
        // A MULDIV held in ID is stalled through DONE, then issues
        for (int i = 1; i <= 4; i++) begin
            chk("bb_stall", PC_LE, 0);
            chk("bb_done", MULDIV_DONE, (i == 4) ? 1 : 0);
            step();
        end
        chk("bb_idle", MULDIV_BUSY, 0);
        chk("bb_issue", PC_LE, 1);
        step();
        chk("bb_busy_again", MULDIV_BUSY, 1);
        clr();
        for (int i = 0; i < 4; i++) step();
        chk("bb_drained", MULDIV_BUSY, 0);

        // A MULDIV held by load-use does not start the FSM
        ID_IS_MULDIV = 1; ID_RS = 5'd9; ID_USES_RS = 1;
        EX_REGEX = 5'd9; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
        #1 chk("lu_md_stall", PC_LE, 0);
        step();
        chk("lu_md_no_issue", MULDIV_BUSY, 0);
        clr();

        // Saturation of a 4-bit stall counter
        Reset = 1'b1;
        #2 Reset = 1'b0;
        EX_REGEX = 5'd8; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
        ID_RT = 5'd8; ID_USES_RT = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) chk("sat_reach15", stall_count4, 15);
        end
        chk("sat_hold15", stall_count4, 15);
        chk("wide_count20", STALL_COUNT, 20);
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
